// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch engine: FSM states, BCD digit and
// packed HH:MM:SS layout, plus the preset validity check.
package stopwatch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} sw_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int NDIG = 6;

    typedef struct packed {
        bcd_digit_t h1;
        bcd_digit_t h0;
        bcd_digit_t m1;
        bcd_digit_t m0;
        bcd_digit_t s1;
        bcd_digit_t s0;
    } hms_bcd_t;

    // True when every digit is legal BCD, tens of minutes/seconds are <= 5 and
    // the hour value is below the hour modulus.
    function automatic logic bcd_valid_hms(input hms_bcd_t t, input int hour_mod);
        int hours;
        hours = int'(t.h1) * 10 + int'(t.h0);
        return (t.h1 <= 4'd9) && (t.h0 <= 4'd9) &&
               (t.m1 <= 4'd5) && (t.m0 <= 4'd9) &&
               (t.s1 <= 4'd5) && (t.s0 <= 4'd9) &&
               (hours < hour_mod);
    endfunction

endpackage

// File: rtl/hms_bcd_counter.sv
// HH:MM:SS BCD up/down counter with synchronous load; hours wrap at HOUR_MOD.
// Also exposes its next value so the parent can register a display copy in step.
module hms_bcd_counter
    import stopwatch_pkg::*;
#(
    parameter int HOUR_MOD = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        step,
    input  logic        down,
    input  logic        load_en,
    input  logic [23:0] load_val,
    output logic [23:0] time_val,
    output logic [23:0] time_nxt,
    output logic        at_zero
);

    localparam bcd_digit_t HMAX1 = bcd_digit_t'((HOUR_MOD - 1) / 10);
    localparam bcd_digit_t HMAX0 = bcd_digit_t'((HOUR_MOD - 1) % 10);

    function automatic bcd_digit_t dig_inc(input bcd_digit_t d, input bcd_digit_t top);
        return (d == top) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic bcd_digit_t dig_dec(input bcd_digit_t d, input bcd_digit_t top);
        return (d == 4'd0) ? top : d - 4'd1;
    endfunction

    hms_bcd_t cur_q, inc, dec, nxt;
    logic     c0, c1, c2, c3, b0, b1, b2, b3;

    // Carry/borrow chain: each digit moves only when all lower digits roll over.
    assign c0 = (cur_q.s0 == 4'd9);
    assign c1 = c0 && (cur_q.s1 == 4'd5);
    assign c2 = c1 && (cur_q.m0 == 4'd9);
    assign c3 = c2 && (cur_q.m1 == 4'd5);
    assign b0 = (cur_q.s0 == 4'd0);
    assign b1 = b0 && (cur_q.s1 == 4'd0);
    assign b2 = b1 && (cur_q.m0 == 4'd0);
    assign b3 = b2 && (cur_q.m1 == 4'd0);

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        inc    = cur_q;
        inc.s0 = dig_inc(cur_q.s0, 4'd9);
        if (c0) inc.s1 = dig_inc(cur_q.s1, 4'd5);
        if (c1) inc.m0 = dig_inc(cur_q.m0, 4'd9);
        if (c2) inc.m1 = dig_inc(cur_q.m1, 4'd5);
        if (c3) begin
            if (cur_q.h1 == HMAX1 && cur_q.h0 == HMAX0) begin
                inc.h1 = 4'd0;
                inc.h0 = 4'd0;
            end else begin
                inc.h0 = dig_inc(cur_q.h0, 4'd9);
                if (cur_q.h0 == 4'd9) inc.h1 = cur_q.h1 + 4'd1;
            end
        end

        dec    = cur_q;
        dec.s0 = dig_dec(cur_q.s0, 4'd9);
        if (b0) dec.s1 = dig_dec(cur_q.s1, 4'd5);
        if (b1) dec.m0 = dig_dec(cur_q.m0, 4'd9);
        if (b2) dec.m1 = dig_dec(cur_q.m1, 4'd5);
        if (b3) begin
            if (cur_q.h1 == 4'd0 && cur_q.h0 == 4'd0) begin
                dec.h1 = HMAX1;
                dec.h0 = HMAX0;
            end else begin
                dec.h0 = dig_dec(cur_q.h0, 4'd9);
                if (cur_q.h0 == 4'd0) dec.h1 = cur_q.h1 - 4'd1;
            end
        end

        nxt = cur_q;
        if (load_en)   nxt = hms_bcd_t'(load_val);
        else if (step) nxt = down ? dec : inc;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cur_q <= '0;
        else          cur_q <= nxt;
    end

    assign time_val = cur_q;
    assign time_nxt = nxt;
    assign at_zero  = (cur_q == '0);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch/timer engine: tick prescaler, run/pause/done FSM, preset load and
// lap freeze around an HH:MM:SS BCD counter.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 1,
    parameter int HOUR_MOD = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    input  logic        load,
    input  logic        dir_down,
    input  logic [23:0] preset_bcd,
    output logic [23:0] bcd_out,
    output logic        running,
    output logic        lap_active,
    output logic        tick,
    output logic        alarm,
    output logic        load_err
);

    localparam int            DIV      = CLK_HZ / TICK_HZ;
    localparam int            PW       = $clog2(DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [23:0]   ONE_SEC  = 24'h000001;

    sw_state_t     state_q, state_d;
    logic [PW-1:0] pre_q;
    logic [23:0]   time_q, time_nxt, cnt_load_val, bcd_q, bcd_d;
    logic          at_zero, lap_q, lap_d, alarm_q, load_err_q;
    logic          load_ok, do_load, load_accept, load_reject, do_ss, do_lap;
    logic          hit_zero, step, cnt_load;

    // Command priority: clear > load > start_stop > lap.
    assign tick         = (state_q == RUN) && (pre_q == PRE_LAST);
    assign load_ok      = bcd_valid_hms(hms_bcd_t'(preset_bcd), HOUR_MOD);
    assign do_load      = load && !clear;
    assign load_accept  = do_load && load_ok && (state_q != RUN);
    assign load_reject  = do_load && !load_accept;
    assign do_ss        = start_stop && !clear && !load;
    assign do_lap       = lap && !clear && !load && !start_stop;
    assign hit_zero     = tick && dir_down && (time_q == ONE_SEC);
    assign step         = tick && !clear;
    assign cnt_load     = clear || load_accept;
    assign cnt_load_val = clear ? 24'h0 : preset_bcd;

    hms_bcd_counter #(.HOUR_MOD(HOUR_MOD)) u_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .step     (step),
        .down     (dir_down),
        .load_en  (cnt_load),
        .load_val (cnt_load_val),
        .time_val (time_q),
        .time_nxt (time_nxt),
        .at_zero  (at_zero)
    );

    always_comb begin
        state_d = state_q;
        if (clear)            state_d = IDLE;
        else if (load_accept) state_d = PAUSE;
        else if (hit_zero)    state_d = DONE;
        else if (do_ss) begin
            if (state_q == RUN)              state_d = PAUSE;
            else if (!(dir_down && at_zero)) state_d = RUN;
        end
    end

    // The display register follows the counter's next value so it stays aligned
    // with the live time; while frozen it holds the time captured on lap entry.
    always_comb begin
        lap_d = lap_q;
        if (clear)       lap_d = 1'b0;
        else if (do_lap) lap_d = !lap_q;

        bcd_d = time_nxt;
        if (lap_d) bcd_d = lap_q ? bcd_q : time_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            lap_q      <= 1'b0;
            bcd_q      <= '0;
            alarm_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lap_q      <= lap_d;
            bcd_q      <= bcd_d;
            alarm_q    <= hit_zero && !clear;
            load_err_q <= load_reject;
            if (cnt_load || tick)    pre_q <= '0;
            else if (state_q == RUN) pre_q <= pre_q + PW'(1);
        end
    end

    assign bcd_out    = bcd_q;
    assign running    = (state_q == RUN);
    assign lap_active = lap_q;
    assign alarm      = alarm_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed self-checking bench for stopwatch_core at CLK_HZ=10, TICK_HZ=1;
// a second instance with HOUR_MOD=12 shares all stimulus except the preset.
module tb_stopwatch_core;

    localparam int CLK_HZ  = 10;
    localparam int TICK_HZ = 1;
    localparam int DIV     = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_stop = 1'b0, clear = 1'b0, lap = 1'b0, load = 1'b0, dir_down = 1'b0;
    logic [23:0] preset_bcd = '0, preset12 = '0;
    logic [23:0] bcd_out, bcd12;
    logic        running, lap_active, tick, alarm, load_err;
    logic        running12, lap12, tick12, alarm12, load_err12;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    stopwatch_core #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .HOUR_MOD(24)) dut (
        .clk(clk), .reset_n(reset_n), .start_stop(start_stop), .clear(clear),
        .lap(lap), .load(load), .dir_down(dir_down), .preset_bcd(preset_bcd),
        .bcd_out(bcd_out), .running(running), .lap_active(lap_active),
        .tick(tick), .alarm(alarm), .load_err(load_err)
    );

    stopwatch_core #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .HOUR_MOD(12)) dut12 (
        .clk(clk), .reset_n(reset_n), .start_stop(start_stop), .clear(clear),
        .lap(lap), .load(load), .dir_down(dir_down), .preset_bcd(preset12),
        .bcd_out(bcd12), .running(running12), .lap_active(lap12),
        .tick(tick12), .alarm(alarm12), .load_err(load_err12)
    );

    function automatic logic [23:0] to_bcd(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1; @(negedge clk); start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; @(negedge clk); clear = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1; @(negedge clk); lap = 1'b0;
    endtask

    task automatic pulse_load(input logic [23:0] v, input logic [23:0] v12);
        preset_bcd = v; preset12 = v12;
        load = 1'b1; @(negedge clk); load = 1'b0;
    endtask

    // Returns in the cycle after the n-th tick, once the time has stepped.
    task automatic wait_ticks(input int n, output int seen);
        int guard;
        seen = 0; guard = 0;
        while (seen < n && guard < n * DIV + 2) begin
            if (tick) seen++;
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cycles(2);
        n_total++;
        if (bcd_out !== 24'h0) begin n_bad++; $display("FAIL reset_bcd: got %h want 000000", bcd_out); end
        n_total++;
        if ({running, lap_active, tick, alarm, load_err} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b want 00000", {running, lap_active, tick, alarm, load_err});
        end
        reset_n = 1'b1;
        cycles(3);
        n_total++;
        if (running !== 1'b0 || bcd_out !== 24'h0) begin
            n_bad++; $display("FAIL idle_after_reset: running=%b bcd=%h want 0/000000", running, bcd_out);
        end
    endtask

    task automatic test_count_up();
        int ticks, first;
        ticks = 0; first = -1;
        dir_down = 1'b0;
        pulse_ss();
        for (int k = 1; k <= 35; k++) begin
            if (tick) begin
                ticks++;
                if (first < 0) first = k;
            end
            @(negedge clk);
        end
        n_total++;
        if (bcd_out !== 24'h000003) begin n_bad++; $display("FAIL up_bcd: got %h want 000003", bcd_out); end
        n_total++;
        if (running !== 1'b1) begin n_bad++; $display("FAIL up_running: got %b want 1", running); end
        n_total++;
        if (ticks != 3) begin n_bad++; $display("FAIL up_tick_count: got %0d want 3", ticks); end
        n_total++;
        if (first != DIV) begin n_bad++; $display("FAIL up_first_tick: got cycle %0d want %0d", first, DIV); end
        pulse_clear();
    endtask

    task automatic test_wrap();
        int seen;
        dir_down = 1'b0;
        pulse_load(24'h235958, 24'h115958);
        n_total++;
        if (bcd_out !== 24'h235958 || bcd12 !== 24'h115958 || load_err !== 1'b0) begin
            n_bad++; $display("FAIL wrap_load: got %h/%h err=%b want 235958/115958 0", bcd_out, bcd12, load_err);
        end
        pulse_ss();
        wait_ticks(1, seen);
        n_total++;
        if (bcd_out !== 24'h235959 || bcd12 !== 24'h115959) begin
            n_bad++; $display("FAIL wrap_max: got %h/%h want 235959/115959", bcd_out, bcd12);
        end
        wait_ticks(1, seen);
        n_total++;
        if (seen != 1) begin n_bad++; $display("FAIL wrap_tick_timeout: got %0d ticks want 1", seen); end
        n_total++;
        if (bcd_out !== 24'h0 || bcd12 !== 24'h0) begin
            n_bad++; $display("FAIL wrap_zero: got %h/%h want 000000/000000", bcd_out, bcd12);
        end
        n_total++;
        if (alarm !== 1'b0 || alarm12 !== 1'b0 || running !== 1'b1) begin
            n_bad++; $display("FAIL wrap_flags: alarm=%b/%b running=%b want 0/0 1", alarm, alarm12, running);
        end
        pulse_clear();
    endtask

    task automatic test_countdown();
        int seen, rem, alarms;
        logic [23:0] expv;
        alarms = 0;
        pulse_load(24'h000101, 24'h000101);
        dir_down = 1'b1;
        pulse_ss();
        for (int i = 1; i <= 61; i++) begin
            wait_ticks(1, seen);
            rem  = 61 - i;
            expv = to_bcd(0, rem / 60, rem % 60);
            if (alarm) alarms++;
            n_total++;
            if (seen != 1 || bcd_out !== expv) begin
                n_bad++; $display("FAIL down_step%0d: got %h (ticks %0d) want %h", i, bcd_out, seen, expv);
            end
        end
        n_total++;
        if (alarms != 1 || alarm !== 1'b1) begin
            n_bad++; $display("FAIL down_alarm: got %0d pulses, now=%b want 1 pulse at zero", alarms, alarm);
        end
        n_total++;
        if (running !== 1'b0) begin n_bad++; $display("FAIL down_done_running: got %b want 0", running); end
        cycles(1);
        n_total++;
        if (alarm !== 1'b0) begin n_bad++; $display("FAIL down_alarm_width: got %b want 0", alarm); end
        pulse_ss();
        cycles(3);
        n_total++;
        if (running !== 1'b0 || bcd_out !== 24'h0) begin
            n_bad++; $display("FAIL down_restart_ignored: running=%b bcd=%h want 0/000000", running, bcd_out);
        end
        pulse_clear();
    endtask

    task automatic test_lap();
        int seen;
        dir_down = 1'b0;
        pulse_ss();
        wait_ticks(5, seen);
        n_total++;
        if (bcd_out !== 24'h000005) begin n_bad++; $display("FAIL lap_pre: got %h want 000005", bcd_out); end
        pulse_lap();
        n_total++;
        if (lap_active !== 1'b1 || bcd_out !== 24'h000005) begin
            n_bad++; $display("FAIL lap_enter: lap=%b bcd=%h want 1/000005", lap_active, bcd_out);
        end
        wait_ticks(3, seen);
        n_total++;
        if (seen != 3 || bcd_out !== 24'h000005) begin
            n_bad++; $display("FAIL lap_hold: got %h (ticks %0d) want 000005", bcd_out, seen);
        end
        pulse_lap();
        n_total++;
        if (lap_active !== 1'b0 || bcd_out !== 24'h000008) begin
            n_bad++; $display("FAIL lap_release: lap=%b bcd=%h want 0/000008", lap_active, bcd_out);
        end
    endtask

    task automatic test_load_err();
        int seen;
        logic [23:0] bad_vals [3];
        bad_vals[0] = 24'h006000;
        bad_vals[1] = 24'h240000;
        bad_vals[2] = 24'h0A0000;
        pulse_ss();
        for (int i = 0; i < 3; i++) begin
            pulse_load(bad_vals[i], bad_vals[i]);
            n_total++;
            if (load_err !== 1'b1 || bcd_out !== 24'h000008) begin
                n_bad++; $display("FAIL load_bad_%h: err=%b bcd=%h want 1/000008", bad_vals[i], load_err, bcd_out);
            end
        end
        cycles(1);
        n_total++;
        if (load_err !== 1'b0 || running !== 1'b0) begin
            n_bad++; $display("FAIL load_err_width: err=%b running=%b want 0/0", load_err, running);
        end
        pulse_ss();
        pulse_load(24'h010000, 24'h010000);
        n_total++;
        if (load_err !== 1'b1 || running !== 1'b1 || bcd_out !== 24'h000008) begin
            n_bad++; $display("FAIL load_in_run: err=%b running=%b bcd=%h want 1/1/000008", load_err, running, bcd_out);
        end
        wait_ticks(1, seen);
        n_total++;
        if (bcd_out !== 24'h000009) begin n_bad++; $display("FAIL load_run_continues: got %h want 000009", bcd_out); end
    endtask

    task automatic test_clear_reset();
        int seen, ticks, first;
        clear = 1'b1; start_stop = 1'b1;
        @(negedge clk);
        clear = 1'b0; start_stop = 1'b0;
        cycles(5);
        n_total++;
        if (running !== 1'b0 || bcd_out !== 24'h0) begin
            n_bad++; $display("FAIL clear_over_start: running=%b bcd=%h want 0/000000", running, bcd_out);
        end
        pulse_ss();
        wait_ticks(2, seen);
        pulse_lap();
        cycles(3);
        n_total++;
        if (bcd_out !== 24'h000002 || lap_active !== 1'b1 || running !== 1'b1) begin
            n_bad++; $display("FAIL pre_reset: bcd=%h lap=%b run=%b want 000002/1/1", bcd_out, lap_active, running);
        end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if (bcd_out !== 24'h0 || {running, lap_active, tick, alarm, load_err} !== 5'b0) begin
            n_bad++; $display("FAIL async_reset: bcd=%h flags=%b want 000000/00000", bcd_out,
                              {running, lap_active, tick, alarm, load_err});
        end
        @(negedge clk);
        reset_n = 1'b1;
        ticks = 0;
        for (int k = 0; k < 25; k++) begin
            if (tick) ticks++;
            @(negedge clk);
        end
        n_total++;
        if (ticks != 0 || bcd_out !== 24'h0 || running !== 1'b0) begin
            n_bad++; $display("FAIL post_reset_idle: ticks=%0d bcd=%h run=%b want 0/000000/0", ticks, bcd_out, running);
        end
        pulse_ss();
        first = -1;
        for (int k = 1; k <= 2 * DIV && first < 0; k++) begin
            if (tick) first = k;
            @(negedge clk);
        end
        n_total++;
        if (first != DIV || bcd_out !== 24'h000001) begin
            n_bad++; $display("FAIL post_reset_resume: first tick %0d bcd=%h want %0d/000001", first, bcd_out, DIV);
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap();
        test_countdown();
        test_lap();
        test_load_err();
        test_clear_reset();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
Parametrised stopwatch/timer engine producing a 6-digit BCD HH:MM:SS value from the system clock. It generalises the fixed 1 Hz up/pause stopwatch with a configurable tick rate, a configurable hour modulus, up and down (countdown) modes, preset load, lap freeze and an end-of-countdown alarm. It sits between the key FSM/debouncers (single-cycle command pulses) and displayNdigit, which consumes bcd_out.

Parameters:
CLK_HZ, 50_000_000, input clock frequency in Hz
TICK_HZ, 1, count rate in Hz; DIV = CLK_HZ/TICK_HZ, must be >= 2 and an integer
HOUR_MOD, 24, hour wrap modulus, legal range 1..100; hours count 0..HOUR_MOD-1

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
start_stop  in  1  1-cycle pulse; toggles run/pause
clear  in  1  1-cycle pulse; zero time, go idle
lap  in  1  1-cycle pulse; toggles lap freeze of bcd_out
load  in  1  1-cycle pulse; load preset_bcd into time (not while running)
dir_down  in  1  level; 1 = count down, 0 = count up
preset_bcd  in  24  {H1,H0,M1,M0,S1,S0}, 4 bits per digit
bcd_out  out  24  displayed time, same packing as preset_bcd
running  out  1  high in RUN state
lap_active  out  1  high while display is frozen
tick  out  1  1-cycle pulse on each count step
alarm  out  1  1-cycle pulse when a countdown reaches 00:00:00
load_err  out  1  1-cycle pulse when a load is rejected

Behaviour:
- Reset (async, reset_n=0): state IDLE, time 00:00:00, prescaler 0, all outputs 0, bcd_out 0.
- States: IDLE, RUN, PAUSE, DONE. Transitions:
  IDLE/PAUSE --start_stop--> RUN. In down mode at 00:00:00 the start is ignored.
  RUN --start_stop--> PAUSE. DONE --start_stop--> RUN, only if dir_down=0 or time != 0.
  Any state --clear--> IDLE.
  RUN, down mode, step from 00:00:01 to 00:00:00 --> DONE.
- Command priority within one cycle: clear > load > start_stop > lap. Lower-priority pulses in the same cycle are dropped.
- Prescaler: 0..DIV-1, counts only in RUN. It holds in PAUSE and resets to 0 on clear, load and reset. tick is asserted in the cycle the prescaler equals DIV-1. The time register updates on the next edge, so bcd_out changes 1 cycle after tick (lap off).
- First tick after RUN is entered from prescaler 0 arrives DIV cycles later.
- Up step: S0 9->0 carries to S1; S1 5->0 carries to M0; M0 9->0 carries to M1; M1 5->0 carries to hours. Hours, as a 2-digit BCD value, wrap HOUR_MOD-1 -> 0. Max value (HOUR_MOD-1):59:59 wraps to 00:00:00 with no alarm.
- Down step: mirror of the up step with borrows. 00:00:00 is never decremented, because DONE is entered first.
- alarm pulses in the same cycle the time register becomes 00:00:00 in down mode. After that, running=0.
- dir_down is sampled at each tick. A mid-run change takes effect on the next step.
- load: accepted in IDLE, PAUSE and DONE. It is valid only if every digit is <= 9, S1 <= 5, M1 <= 5 and hours < HOUR_MOD.
  Valid load: time = preset, state becomes PAUSE, prescaler 0.
  Invalid load, or load while in RUN: no change, load_err pulse.
- lap: toggles lap_active in any state.
  On assertion, bcd_out latches the current time and holds it; counting continues underneath.
  On deassertion, bcd_out resumes tracking live time in the same cycle.
  clear also drops lap_active.
- bcd_out is registered. It equals the time register when lap_active=0.

Decomposition:
- Package stopwatch_pkg:
  - state enum sw_state_t {IDLE, RUN, PAUSE, DONE}
  - typedef bcd_digit_t logic [3:0]
  - localparam NDIG = 6
  - packed struct hms_bcd_t {h1,h0,m1,m0,s1,s0}
  - function bcd_valid_hms (used for load validation)
- One sub-module, hms_bcd_counter:
  - inputs: step, down, load_en, load_val
  - outputs: time value, at_zero flag
  - parameter: HOUR_MOD
- Prescaler, FSM and lap latch stay in stopwatch_core.

Test Plan:
1. Sim params CLK_HZ=10, TICK_HZ=1 (DIV=10). Reset, start_stop, wait 35 cycles -> bcd_out=00:00:03, running=1, exactly 3 tick pulses, first at cycle 10 after start.
2. Load 23:59:58, start in up mode, run 2 ticks -> 23:59:59 then 00:00:00, alarm=0. Repeat with HOUR_MOD=12: 11:59:59 -> 00:00:00.
3. Load 00:01:01, dir_down=1, start, run 61 ticks -> 00:01:00, 00:00:59, ..., 00:00:00. alarm pulses once, state DONE, running=0. A further start_stop is ignored.
4. Run up to 00:00:05, pulse lap -> bcd_out held at 00:00:05 for 3 ticks while internal time reaches 00:00:08. Pulse lap again -> bcd_out=00:00:08 immediately.
5. Loads of 00:60:00, 24:00:00 (HOUR_MOD=24) and 0A:00:00 -> load_err pulse each time, time unchanged. Load during RUN -> load_err, counting continues.
6. Same-cycle clear+start_stop while running -> IDLE, 00:00:00. Drive reset_n low mid-prescale (async, between edges) -> all outputs 0 immediately. After release, count resumes only after a new start_stop.
